// File: rtl/snake_pkg.sv
// Shared definitions for the snake body logic: grid/depth defaults,
// direction encoding and the body-walker state encoding.
package snake_pkg;

   localparam int unsigned SNAKE_X_BITS   = 4;
   localparam int unsigned SNAKE_Y_BITS   = 4;
   localparam int unsigned SNAKE_DEPTH    = 234;
   localparam int unsigned SNAKE_LEN_BITS = 8;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_SYNC,
      ST_WALK,
      ST_DONE
   } walk_state_t;

endpackage

// File: rtl/snake_pos_step.sv
// One grid step along a direction with natural wrap; fwd_i=0 undoes the
// move (walker), fwd_i=1 applies it (movement logic).
module snake_pos_step
   import snake_pkg::*;
#(
   parameter int unsigned X_BITS = SNAKE_X_BITS,
   parameter int unsigned Y_BITS = SNAKE_Y_BITS
) (
   input  logic [X_BITS-1:0] x_i,
   input  logic [Y_BITS-1:0] y_i,
   input  dir_t              dir_i,
   input  logic              fwd_i,
   output logic [X_BITS-1:0] x_o,
   output logic [Y_BITS-1:0] y_o
);

   always_comb begin
      x_o = x_i;
      y_o = y_i;
      case (dir_i)
         DIR_UP:    y_o = fwd_i ? y_i - Y_BITS'(1) : y_i + Y_BITS'(1);
         DIR_RIGHT: x_o = fwd_i ? x_i + X_BITS'(1) : x_i - X_BITS'(1);
         DIR_DOWN:  y_o = fwd_i ? y_i + Y_BITS'(1) : y_i - Y_BITS'(1);
         DIR_LEFT:  x_o = fwd_i ? x_i - X_BITS'(1) : x_i + X_BITS'(1);
         default: ;
      endcase
   end

endmodule

// File: rtl/snake_body_walker.sv
// Replays the recirculating direction stream from head to tail, reporting
// first body hit on a query cell and the tail coordinate.
module snake_body_walker
   import snake_pkg::*;
#(
   parameter int unsigned X_BITS   = SNAKE_X_BITS,
   parameter int unsigned Y_BITS   = SNAKE_Y_BITS,
   parameter int unsigned DEPTH    = SNAKE_DEPTH,
   parameter int unsigned LEN_BITS = SNAKE_LEN_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [X_BITS-1:0]   head_x,
   input  logic [Y_BITS-1:0]   head_y,
   input  logic [LEN_BITS-1:0] length,
   input  logic [X_BITS-1:0]   query_x,
   input  logic [Y_BITS-1:0]   query_y,
   input  logic [1:0]          sr_dir,
   input  logic                sr_sync,
   output logic                busy,
   output logic                done,
   output logic                hit,
   output logic [LEN_BITS-1:0] hit_index,
   output logic [X_BITS-1:0]   tail_x,
   output logic [Y_BITS-1:0]   tail_y
);

   walk_state_t         state_q;
   logic [X_BITS-1:0]   cur_x_q, qry_x_q, tail_x_q;
   logic [Y_BITS-1:0]   cur_y_q, qry_y_q, tail_y_q;
   logic [LEN_BITS-1:0] len_q, idx_q, acc_idx_q, hit_index_q;
   logic                acc_hit_q, hit_q, busy_q, done_q;

   logic [LEN_BITS-1:0] len_d, acc_idx_d;
   logic [X_BITS-1:0]   step_x;
   logic [Y_BITS-1:0]   step_y;
   logic                seg_match, acc_hit_d, last_seg;

   always_comb begin
      len_d = length;
      if (length == '0)
         len_d = LEN_BITS'(1);
      else if (length > LEN_BITS'(DEPTH))
         len_d = LEN_BITS'(DEPTH);
   end

   snake_pos_step #(
      .X_BITS (X_BITS),
      .Y_BITS (Y_BITS)
   ) u_step (
      .x_i   (cur_x_q),
      .y_i   (cur_y_q),
      .dir_i (dir_t'(sr_dir)),
      .fwd_i (1'b0),
      .x_o   (step_x),
      .y_o   (step_y)
   );

   // cur holds the segment compared this cycle; head is loaded into it on start
   always_comb begin
      seg_match = (cur_x_q == qry_x_q) && (cur_y_q == qry_y_q);
      acc_hit_d = acc_hit_q | seg_match;
      acc_idx_d = (seg_match && !acc_hit_q) ? idx_q : acc_idx_q;
      last_seg  = (idx_q == len_q - LEN_BITS'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cur_x_q     <= '0;
         cur_y_q     <= '0;
         qry_x_q     <= '0;
         qry_y_q     <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         acc_hit_q   <= 1'b0;
         acc_idx_q   <= '0;
         hit_q       <= 1'b0;
         hit_index_q <= '0;
         tail_x_q    <= '0;
         tail_y_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  cur_x_q   <= head_x;
                  cur_y_q   <= head_y;
                  qry_x_q   <= query_x;
                  qry_y_q   <= query_y;
                  len_q     <= len_d;
                  idx_q     <= '0;
                  acc_hit_q <= 1'b0;
                  acc_idx_q <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_WAIT_SYNC;
               end
            end
            ST_WAIT_SYNC, ST_WALK: begin
               if (state_q == ST_WALK || sr_sync) begin
                  cur_x_q   <= step_x;
                  cur_y_q   <= step_y;
                  idx_q     <= idx_q + LEN_BITS'(1);
                  acc_hit_q <= acc_hit_d;
                  acc_idx_q <= acc_idx_d;
                  if (last_seg) begin
                     hit_q       <= acc_hit_d;
                     hit_index_q <= acc_idx_d;
                     tail_x_q    <= cur_x_q;
                     tail_y_q    <= cur_y_q;
                     done_q      <= 1'b1;
                     state_q     <= ST_DONE;
                  end else begin
                     state_q <= ST_WALK;
                  end
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign hit       = hit_q;
   assign hit_index = hit_index_q;
   assign tail_x    = tail_x_q;
   assign tail_y    = tail_y_q;

endmodule

// File: tb/tb_snake_body_walker.sv
// Scoreboard bench for snake_body_walker: a recirculating direction stream,
// a reference walk model, and result/timing checks on every done strobe.
module tb_snake_body_walker;

   localparam int DEPTH = 234;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] head_x = '0, head_y = '0, query_x = '0, query_y = '0;
   logic [7:0] length = '0;
   logic [1:0] sr_dir;
   logic       sr_sync;
   logic       busy, done, hit;
   logic [7:0] hit_index;
   logic [3:0] tail_x, tail_y;

   always #5 clk = ~clk;

   snake_body_walker dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .head_x    (head_x),
      .head_y    (head_y),
      .length    (length),
      .query_x   (query_x),
      .query_y   (query_y),
      .sr_dir    (sr_dir),
      .sr_sync   (sr_sync),
      .busy      (busy),
      .done      (done),
      .hit       (hit),
      .hit_index (hit_index),
      .tail_x    (tail_x),
      .tail_y    (tail_y)
   );

   typedef struct {
      logic        hit;
      int          idx;
      int          tx;
      int          ty;
      int          done_cyc;
   } exp_t;

   exp_t       sb[$];
   logic [1:0] dirs [DEPTH];
   int         cyc = 0;
   int         phase = 0;
   int         n_checks = 0;
   int         n_pass = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      else
         n_pass++;
   endtask

   // advance to the next cycle: stream element for the new cycle is driven #1 after the edge
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      phase   = (phase + 1) % DEPTH;
      sr_dir  = dirs[phase];
      sr_sync = (phase == 0);
   endtask

   function automatic exp_t model(input int hx, input int hy, input int len,
                                  input int qx, input int qy, input int s, input int ps);
      exp_t e;
      int   eff, x, y, dx, dy;
      eff = (len == 0) ? 1 : (len > DEPTH ? DEPTH : len);
      x = hx; y = hy;
      e.hit = 1'b0; e.idx = 0; e.tx = 0; e.ty = 0;
      for (int k = 0; k < eff; k++) begin
         if (!e.hit && x == qx && y == qy) begin
            e.hit = 1'b1;
            e.idx = k;
         end
         if (k == eff - 1) begin
            e.tx = x;
            e.ty = y;
         end
         dx = (dirs[k] == 2'd1) ? 1 : (dirs[k] == 2'd3) ? -1 : 0;
         dy = (dirs[k] == 2'd0) ? -1 : (dirs[k] == 2'd2) ? 1 : 0;
         x = (x - dx + 16) % 16;
         y = (y - dy + 16) % 16;
      end
      e.done_cyc = s + (DEPTH - ps) + eff;
      return e;
   endfunction

   task automatic do_start(input int hx, input int hy, input int len,
                           input int qx, input int qy, input bit expect_it);
      head_x  = 4'(hx);
      head_y  = 4'(hy);
      length  = 8'(len);
      query_x = 4'(qx);
      query_y = 4'(qy);
      start   = 1'b1;
      if (expect_it)
         sb.push_back(model(hx, hy, len, qx, qy, cyc, phase));
      tick();
      start = 1'b0;
      chk("busy_after_start", int'(busy), 1);
   endtask

   task automatic wait_idle(input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (sb.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok)
         chk("wait_idle_timeout", 0, 1);
      else
         chk("idle_busy_low", int'(busy), 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               chk("spurious_done", int'(done), 0);
            end else begin
               e = sb.pop_front();
               chk("hit", int'(hit), int'(e.hit));
               chk("hit_index", int'(hit_index), e.idx);
               chk("tail_x", int'(tail_x), e.tx);
               chk("tail_y", int'(tail_y), e.ty);
               chk("done_cycle", cyc, e.done_cyc);
            end
         end
      end
   end

   initial begin : stim
      for (int i = 0; i < DEPTH; i++)
         dirs[i] = 2'($urandom_range(0, 3));
      sr_dir  = dirs[0];
      sr_sync = 1'b1;

      repeat (3) tick();
      rst = 1'b0;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_hit", int'(hit), 0);
      chk("rst_hit_index", int'(hit_index), 0);
      chk("rst_tail_x", int'(tail_x), 0);
      chk("rst_tail_y", int'(tail_y), 0);

      // basic walk
      dirs[0] = 2'd1; dirs[1] = 2'd1;
      do_start(5, 5, 3, 3, 5, 1'b1);
      wait_idle(600);

      // wrap around the left edge
      dirs[0] = 2'd1;
      do_start(0, 0, 2, 15, 0, 1'b1);
      wait_idle(600);

      // self overlap, first match kept
      dirs[0] = 2'd0; dirs[1] = 2'd1; dirs[2] = 2'd2; dirs[3] = 2'd3;
      do_start(2, 2, 5, 2, 2, 1'b1);
      wait_idle(600);

      // no hit, length 1, length 0
      do_start(5, 5, 4, 9, 9, 1'b1);
      wait_idle(600);
      do_start(7, 3, 1, 0, 0, 1'b1);
      wait_idle(600);
      do_start(4, 4, 0, 4, 4, 1'b1);
      wait_idle(600);

      // clamp to DEPTH
      for (int i = 4; i < DEPTH; i++)
         dirs[i] = 2'($urandom_range(0, 3));
      do_start(8, 8, 250, 3, 12, 1'b1);
      wait_idle(800);

      // start coincident with sync waits for the next one
      for (int i = 0; i < DEPTH + 2; i++) begin
         if (phase == 0) break;
         tick();
      end
      do_start(1, 2, 6, 1, 3, 1'b1);
      wait_idle(800);

      // second start while busy is ignored
      do_start(6, 9, 5, 5, 9, 1'b1);
      tick();
      do_start(1, 1, 1, 1, 1, 1'b0);
      wait_idle(800);

      // reset mid-walk after a prior hit result
      dirs[0] = 2'd1; dirs[1] = 2'd1;
      do_start(5, 5, 3, 3, 5, 1'b1);
      wait_idle(600);
      do_start(10, 10, 100, 0, 0, 1'b1);
      for (int i = 0; i < DEPTH + 2; i++) begin
         if (sr_sync) break;
         tick();
      end
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      void'(sb.pop_back());
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_hit", int'(hit), 0);
      chk("midrst_hit_index", int'(hit_index), 0);
      chk("midrst_tail_x", int'(tail_x), 0);
      chk("midrst_tail_y", int'(tail_y), 0);
      repeat (300) tick();
      chk("midrst_still_idle", int'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
